core_dispatch: RTL and testbench

CORE_DISPATCH -- requirements
Module: core_dispatch

---
 rtl/core_dispatch_pkg.sv | 20 ++
 rtl/core_dispatch_busy_tracker.sv | 23 ++
 rtl/core_dispatch.sv | 124 ++++++++++++
 tb/tb_core_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatch_pkg.sv
// Shared GPU dispatch definitions: FSM state and fence encodings used by
// the dispatcher and its bench-facing interface.
package core_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // 2'b11 is reserved and behaves exactly like FENCE_NONE.
    typedef enum logic [1:0] {
        FENCE_NONE     = 2'b00,
        FENCE_RELEASE  = 2'b01,
        FENCE_ACQUIRE  = 2'b10,
        FENCE_RESERVED = 2'b11
    } fence_t;

endpackage

// File: rtl/core_dispatch_busy_tracker.sv
// Per-core busy bookkeeping: a core becomes busy when its task's last word is
// issued and idles on its done pulse; a coinciding set wins over done.
module core_busy_tracker #(
    parameter int CORE_NUM = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CORE_NUM-1:0] set,
    input  logic [CORE_NUM-1:0] done,
    output logic [CORE_NUM-1:0] mask
);

    // Done pulses on idle cores fall out naturally: clearing a 0 bit is a no-op.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else begin
            mask <= (mask & ~done) | set;
        end
    end

endmodule

// File: rtl/core_dispatch.sv
// Task dispatcher: accepts a task descriptor, waits for target cores to be free,
// then broadcasts its instruction words. Fence support: define CORE_DISPATCH_FENCE_EN.
module core_dispatch
    import core_dispatch_pkg::*;
#(
    parameter int CORE_NUM   = 16,
    parameter int INSTR_SIZE = 16,
    parameter int LEN_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  task_valid,
    output logic                  task_ready,
    input  logic [CORE_NUM-1:0]   task_mask,
    input  logic [1:0]            task_fence,
    input  logic [LEN_W-1:0]      task_len,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_SIZE-1:0] instr_data,
    input  logic [CORE_NUM-1:0]   core_done,
    output logic [CORE_NUM-1:0]   core_load,
    output logic [INSTR_SIZE-1:0] core_word,
    output logic [CORE_NUM-1:0]   busy_mask,
    output logic                  task_active
);

    state_t              state;
    state_t              state_next;
    logic [CORE_NUM-1:0] lat_mask;
    logic [LEN_W-1:0]    count;
    logic [CORE_NUM-1:0] set_mask;
    logic                accept;
    logic                last_word;
    logic                overlap_free;
    logic                wait_go;
    logic                is_release;
    logic                is_acquire;
    logic                take_task;

    assign take_task    = (state == ST_IDLE) && task_valid;
    assign accept       = (state == ST_STREAM) && instr_valid;
    assign last_word    = (count == LEN_W'(1));
    assign overlap_free = ((lat_mask & busy_mask) == '0);
    assign wait_go      = overlap_free && (!is_release || (busy_mask == '0));

`ifdef CORE_DISPATCH_FENCE_EN
    fence_t lat_fence;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_fence <= FENCE_NONE;
        end else if (take_task) begin
            lat_fence <= fence_t'(task_fence);
        end
    end

    assign is_release = (lat_fence == FENCE_RELEASE);
    assign is_acquire = (lat_fence == FENCE_ACQUIRE);
`else
    logic unused_fence;

    assign unused_fence = ^task_fence;
    assign is_release   = 1'b0;
    assign is_acquire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (task_valid) state_next = ST_WAIT;
            ST_WAIT:   if (wait_go) state_next = (count == '0) ? ST_IDLE : ST_STREAM;
            ST_STREAM: if (accept && last_word) state_next = is_acquire ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (overlap_free) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        task_ready  = (state == ST_IDLE);
        instr_ready = (state == ST_STREAM);
        task_active = (state != ST_IDLE);
        set_mask    = (accept && last_word) ? lat_mask : '0;
    end

    // Descriptor latch, word counter and the one-cycle-latency word broadcast.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_mask  <= '0;
            count     <= '0;
            core_load <= '0;
            core_word <= '0;
        end else begin
            core_load <= accept ? lat_mask : '0;
            if (accept) begin
                core_word <= instr_data;
                count     <= count - LEN_W'(1);
            end
            if (take_task) begin
                lat_mask <= task_mask;
                count    <= task_len;
            end
        end
    end

    core_busy_tracker #(
        .CORE_NUM(CORE_NUM)
    ) u_busy (
        .clk  (clk),
        .reset(reset),
        .set  (set_mask),
        .done (core_done),
        .mask (busy_mask)
    );

endmodule

// File: tb/tb_core_dispatch.sv
// Self-checking bench for core_dispatch: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_core_dispatch;

    localparam int N = 16;
    localparam int W = 16;
    localparam int L = 6;
`ifdef CORE_DISPATCH_FENCE_EN
    localparam bit FENCE_EN = 1'b1;
`else
    localparam bit FENCE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         task_valid;
    logic         task_ready;
    logic [N-1:0] task_mask;
    logic [1:0]   task_fence;
    logic [L-1:0] task_len;
    logic         instr_valid;
    logic         instr_ready;
    logic [W-1:0] instr_data;
    logic [N-1:0] core_done;
    logic [N-1:0] core_load;
    logic [W-1:0] core_word;
    logic [N-1:0] busy_mask;
    logic         task_active;

    int checks   = 0;
    int failures = 0;

    core_dispatch #(.CORE_NUM(N), .INSTR_SIZE(W), .LEN_W(L)) dut (
        .clk(clk), .reset(reset),
        .task_valid(task_valid), .task_ready(task_ready),
        .task_mask(task_mask), .task_fence(task_fence), .task_len(task_len),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .core_done(core_done), .core_load(core_load), .core_word(core_word),
        .busy_mask(busy_mask), .task_active(task_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the dispatcher's phase (idle / waiting for cores /
    // streaming words / draining), the outstanding task and the busy cores.
    typedef enum int {P_IDLE, P_WAIT, P_STREAM, P_DRAIN} phase_t;
    phase_t       m_phase, n_phase;
    logic [N-1:0] m_busy, n_busy, m_mask, n_mask, m_load, n_load;
    logic [W-1:0] m_word, n_word;
    logic [1:0]   m_fence, n_fence;
    int           m_left, n_left;

    task automatic model_reset();
        m_phase = P_IDLE; m_busy = '0; m_mask = '0; m_load = '0;
        m_word = '0; m_fence = 2'b00; m_left = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] issued;
        logic release_f, acquire_f;
        issued    = '0;
        release_f = FENCE_EN && (m_fence == 2'b01);
        acquire_f = FENCE_EN && (m_fence == 2'b10);
        n_phase = m_phase; n_mask = m_mask; n_fence = m_fence; n_left = m_left;
        n_word  = m_word;  n_load = '0;
        case (m_phase)
            P_IDLE: if (task_valid) begin
                n_mask = task_mask; n_fence = task_fence; n_left = int'(task_len);
                n_phase = P_WAIT;
            end
            P_WAIT: if ((m_mask & m_busy) == 0 && (!release_f || m_busy == 0))
                n_phase = (m_left == 0) ? P_IDLE : P_STREAM;
            P_STREAM: if (instr_valid) begin
                n_word = instr_data; n_load = m_mask; n_left = m_left - 1;
                if (m_left == 1) begin
                    issued  = m_mask;
                    n_phase = acquire_f ? P_DRAIN : P_IDLE;
                end
            end
            P_DRAIN: if ((m_mask & m_busy) == 0) n_phase = P_IDLE;
            default: n_phase = P_IDLE;
        endcase
        n_busy = (m_busy & ~core_done) | issued;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".task_ready"},  32'(task_ready),  32'(m_phase == P_IDLE));
        check({tag, ".instr_ready"}, 32'(instr_ready), 32'(m_phase == P_STREAM));
        check({tag, ".task_active"}, 32'(task_active), 32'(m_phase != P_IDLE));
        check({tag, ".busy_mask"},   32'(busy_mask),   32'(m_busy));
        check({tag, ".core_load"},   32'(core_load),   32'(m_load));
        check({tag, ".core_word"},   32'(core_word),   32'(m_word));
    endtask

    // One clock: inputs are already driven; advance model and DUT, compare at negedge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        m_phase = n_phase; m_busy = n_busy; m_mask = n_mask; m_load = n_load;
        m_word = n_word; m_fence = n_fence; m_left = n_left;
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        task_valid = 1'b0; task_mask = '0; task_fence = 2'b00; task_len = '0;
        instr_valid = 1'b0; instr_data = '0; core_done = '0;
    endtask

    task automatic send_task(input logic [N-1:0] mask, input logic [1:0] fence,
                             input logic [L-1:0] len, input string tag);
        task_valid = 1'b1; task_mask = mask; task_fence = fence; task_len = len;
        cycle(tag);
        idle_inputs();
    endtask

    task automatic send_word(input logic [W-1:0] data, input string tag);
        instr_valid = 1'b1; instr_data = data;
        cycle(tag);
        instr_valid = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        check({tag, ".load"},   32'(core_load),   32'h0);
        check({tag, ".word"},   32'(core_word),   32'h0);
        check({tag, ".busy"},   32'(busy_mask),   32'h0);
        check({tag, ".active"}, 32'(task_active), 32'h0);
        check({tag, ".iready"}, 32'(instr_ready), 32'h0);
        check({tag, ".tready"}, 32'(task_ready),  32'h1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle({tag, ".post"});
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        reset = 1'b1;
        cycle("post_reset");

        // Three-word task to cores 0/1, no fence.
        send_task(16'h0003, 2'b00, 6'd3, "r032.task");
        cycle("r032.wait");
        send_word(16'hA001, "r032.w1");
        check("r032.load1", 32'(core_load), 32'h0003);
        check("r032.word1", 32'(core_word), 32'hA001);
        send_word(16'hA002, "r032.w2");
        send_word(16'hA003, "r032.w3");
        check("r032.word3", 32'(core_word), 32'hA003);
        check("r032.busy",  32'(busy_mask), 32'h0003);
        check("r032.idle",  32'(task_ready), 32'h1);
        cycle("r032.after");
        core_done = 16'h0003; cycle("r032.done"); core_done = '0;

        // Overlap hold: core 0 busy, new task targets cores 0/1.
        send_task(16'h0001, 2'b00, 6'd1, "r033.pre");
        cycle("r033.prew");
        send_word(16'h1111, "r033.prew1");
        send_task(16'h0003, 2'b00, 6'd1, "r033.task");
        cycle("r033.hold1");
        cycle("r033.hold2");
        check("r033.held", 32'(instr_ready), 32'h0);
        core_done = 16'h0001; cycle("r033.done"); core_done = '0;
        cycle("r033.go");
        check("r033.stream", 32'(instr_ready), 32'h1);
        send_word(16'h2222, "r033.w1");
        core_done = 16'h0003; cycle("r033.clr"); core_done = '0;

        // Acquire fence on core 4.
        send_task(16'h0010, 2'b10, 6'd1, "r034.task");
        cycle("r034.wait");
        send_word(16'h3333, "r034.w1");
        check("r034.drain", 32'(task_active), 32'(FENCE_EN));
        cycle("r034.d1");
        core_done = 16'h0010; cycle("r034.done"); core_done = '0;
        cycle("r034.exit");
        check("r034.tready", 32'(task_ready), 32'h1);

        // Release fence waits for every core, even non-overlapping ones.
        send_task(16'h8000, 2'b00, 6'd1, "r035.pre");
        cycle("r035.prew");
        send_word(16'h4444, "r035.prew1");
        send_task(16'h0001, 2'b01, 6'd1, "r035.task");
        cycle("r035.w1");
        check("r035.gate", 32'(instr_ready), 32'(!FENCE_EN));
        cycle("r035.w2");
        core_done = 16'h8000; cycle("r035.done"); core_done = '0;
        cycle("r035.go");
        instr_valid = 1'b1; instr_data = 16'h5555;
        repeat (2) cycle("r035.word");
        instr_valid = 1'b0;
        core_done = 16'h0001; cycle("r035.clr"); core_done = '0;

        // Done pulse coinciding with the last word's set: set wins.
        send_task(16'h0002, 2'b00, 6'd1, "r037.task");
        cycle("r037.wait");
        core_done = 16'h0002;
        send_word(16'h6666, "r037.w1");
        core_done = '0;
        check("r037.bit1", 32'(busy_mask[1]), 32'h1);
        core_done = 16'h0002; cycle("r037.clr"); core_done = '0;

        // Zero mask: words consumed, nothing loaded, nothing becomes busy.
        send_task(16'h0000, 2'b00, 6'd2, "mask0.task");
        cycle("mask0.wait");
        send_word(16'h7777, "mask0.w1");
        send_word(16'h7778, "mask0.w2");
        check("mask0.load", 32'(core_load), 32'h0);
        check("mask0.busy", 32'(busy_mask), 32'h0);

        // Zero length: WAIT returns straight to IDLE.
        send_task(16'h0004, 2'b00, 6'd0, "len0.task");
        cycle("len0.wait");
        check("len0.idle", 32'(task_ready), 32'h1);

        // Reset in the middle of a four-word task.
        send_task(16'h00F0, 2'b00, 6'd4, "r036.task");
        cycle("r036.wait");
        send_word(16'h8001, "r036.w1");
        send_word(16'h8002, "r036.w2");
        pulse_reset("r036.rst");

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            task_valid  = 1'($urandom_range(0, 1));
            task_mask   = N'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) task_mask = '0;
            task_fence  = 2'($urandom);
            task_len    = L'($urandom_range(0, 5));
            instr_valid = ($urandom_range(0, 3) != 0);
            instr_data  = W'($urandom);
            core_done   = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 799) == 0) pulse_reset("rand.rst");
            else cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
